// File: rtl/kf8255_port_pkg.sv
// Shared types and constants for the 8255-style handshake port.
package kf8255_port_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01,
    MODE_2 = 2'b10
  } mode_e;

  localparam logic PORT_INPUT  = 1'b1;
  localparam logic PORT_OUTPUT = 1'b0;

  // Control-word mode field: 00 = mode 0, 01 = mode 1, 1x = mode 2.
  function automatic mode_e decode_mode(input logic [1:0] sel);
    if (sel[1]) begin
      return MODE_2;
    end else if (sel[0]) begin
      return MODE_1;
    end else begin
      return MODE_0;
    end
  endfunction

endpackage

// File: rtl/kf8255_edge_detect.sv
// Single-register edge detector for an active-low strobe; the register resets high so
// the first fall after reset needs the line to actually go low.
module kf8255_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_sig,
  output logic o_fall,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_fall = r_prev & ~i_sig;
  assign o_rise = ~r_prev & i_sig;

endmodule

// File: rtl/kf8255_handshake_port.sv
// One 8255-style port with mode 0/1/2 strobed handshakes.
// Define KF8255_PORT_SYNC_EN to pass stb_n, ack_n and port_in through two-flop synchronizers.
module kf8255_handshake_port
  import kf8255_port_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        RESET_IO = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] internal_data_bus,
  input  logic             write_port,
  input  logic             read_port,
  input  logic             update_mode,
  input  logic [1:0]       mode_select_reg,
  input  logic             port_io_reg,
  input  logic             inte_reg,
  input  logic             stb_n,
  input  logic             ack_n,
  input  logic [WIDTH-1:0] port_in,
  output logic             port_io,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] read,
  output logic             ibf,
  output logic             obf_n,
  output logic             intr
);

  logic             w_stb_n, w_ack_n;
  logic [WIDTH-1:0] w_port_in;

`ifdef KF8255_PORT_SYNC_EN
  logic [1:0]       r_stb_sync, r_ack_sync;
  logic [WIDTH-1:0] r_in_sync1, r_in_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stb_sync <= 2'b11;
      r_ack_sync <= 2'b11;
      r_in_sync1 <= '0;
      r_in_sync2 <= '0;
    end else begin
      r_stb_sync <= {r_stb_sync[0], stb_n};
      r_ack_sync <= {r_ack_sync[0], ack_n};
      r_in_sync1 <= port_in;
      r_in_sync2 <= r_in_sync1;
    end
  end

  assign w_stb_n   = r_stb_sync[1];
  assign w_ack_n   = r_ack_sync[1];
  assign w_port_in = r_in_sync2;
`else
  assign w_stb_n   = stb_n;
  assign w_ack_n   = ack_n;
  assign w_port_in = port_in;
`endif

  logic w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise;

  kf8255_edge_detect u_stb_edge (
    .clock  (clock),
    .reset  (reset),
    .i_sig  (w_stb_n),
    .o_fall (w_stb_fall),
    .o_rise (w_stb_rise)
  );

  kf8255_edge_detect u_ack_edge (
    .clock  (clock),
    .reset  (reset),
    .i_sig  (w_ack_n),
    .o_fall (w_ack_fall),
    .o_rise (w_ack_rise)
  );

  mode_e w_mode;
  logic  w_in_act, w_out_act;

  assign w_mode    = decode_mode(mode_select_reg);
  assign w_in_act  = (w_mode == MODE_2) || ((w_mode == MODE_1) && (port_io_reg == PORT_INPUT));
  assign w_out_act = (w_mode == MODE_2) || ((w_mode == MODE_1) && (port_io_reg == PORT_OUTPUT));

  logic             r_port_io, r_ibf, r_obf_n, r_intr_in, r_intr_out;
  logic [WIDTH-1:0] r_port_out, r_read_tmp;
  logic             w_port_io_next, w_ibf_next, w_obf_n_next, w_intr_in_next, w_intr_out_next;
  logic [WIDTH-1:0] w_port_out_next, w_read_tmp_next;

  always_comb begin
    w_port_io_next  = (w_mode == MODE_2) ? w_ack_n : port_io_reg;
    w_port_out_next = r_port_out;
    w_read_tmp_next = r_read_tmp;
    w_ibf_next      = r_ibf;
    w_obf_n_next    = r_obf_n;
    w_intr_in_next  = r_intr_in;
    w_intr_out_next = r_intr_out;

    if (write_port) begin
      w_port_out_next = internal_data_bus;
    end
    if (w_mode == MODE_0) begin
      w_read_tmp_next = w_port_in;
    end

    // Set beats clear on the input side: a new strobe outranks a simultaneous read.
    if (w_in_act) begin
      if (w_stb_fall) begin
        w_read_tmp_next = w_port_in;
        w_ibf_next      = 1'b1;
      end else if (read_port) begin
        w_ibf_next = 1'b0;
      end
      if (w_stb_rise && r_ibf && inte_reg) begin
        w_intr_in_next = 1'b1;
      end else if (read_port) begin
        w_intr_in_next = 1'b0;
      end
    end else begin
      w_ibf_next     = 1'b0;
      w_intr_in_next = 1'b0;
    end

    // On the output side the CPU write outranks the peripheral acknowledge.
    if (w_out_act) begin
      if (write_port) begin
        w_obf_n_next    = 1'b0;
        w_intr_out_next = 1'b0;
      end else begin
        if (w_ack_fall) begin
          w_obf_n_next = 1'b1;
        end
        if (w_ack_rise && r_obf_n && inte_reg) begin
          w_intr_out_next = 1'b1;
        end
      end
    end else begin
      w_obf_n_next    = 1'b1;
      w_intr_out_next = 1'b0;
    end

    if (update_mode) begin
      w_port_out_next = '0;
      w_read_tmp_next = '0;
      w_ibf_next      = 1'b0;
      w_obf_n_next    = 1'b1;
      w_intr_in_next  = 1'b0;
      w_intr_out_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_port_io  <= RESET_IO;
      r_port_out <= '0;
      r_read_tmp <= '0;
      r_ibf      <= 1'b0;
      r_obf_n    <= 1'b1;
      r_intr_in  <= 1'b0;
      r_intr_out <= 1'b0;
    end else begin
      r_port_io  <= w_port_io_next;
      r_port_out <= w_port_out_next;
      r_read_tmp <= w_read_tmp_next;
      r_ibf      <= w_ibf_next;
      r_obf_n    <= w_obf_n_next;
      r_intr_in  <= w_intr_in_next;
      r_intr_out <= w_intr_out_next;
    end
  end

  assign port_io  = r_port_io;
  assign port_out = r_port_out;
  assign read     = r_port_io ? r_read_tmp : r_port_out;
  assign ibf      = r_ibf;
  assign obf_n    = r_obf_n;
  assign intr     = r_intr_in | r_intr_out;

endmodule

// File: tb/tb_kf8255_handshake_port.sv
// Self-checking bench for kf8255_handshake_port: directed vector table, reset sequence,
// then randomized traffic against a flag-level reference model.
module tb_kf8255_handshake_port;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] internal_data_bus = '0;
  logic       write_port = 1'b0, read_port = 1'b0, update_mode = 1'b0;
  logic [1:0] mode_select_reg = 2'b00;
  logic       port_io_reg = 1'b1, inte_reg = 1'b0, stb_n = 1'b1, ack_n = 1'b1;
  logic [7:0] port_in = '0;
  logic       port_io, ibf, obf_n, intr;
  logic [7:0] port_out, read;

  kf8255_handshake_port #(.WIDTH(8), .RESET_IO(1'b1)) dut (
    .clock             (clock),
    .reset             (reset),
    .internal_data_bus (internal_data_bus),
    .write_port        (write_port),
    .read_port         (read_port),
    .update_mode       (update_mode),
    .mode_select_reg   (mode_select_reg),
    .port_io_reg       (port_io_reg),
    .inte_reg          (inte_reg),
    .stb_n             (stb_n),
    .ack_n             (ack_n),
    .port_in           (port_in),
    .port_io           (port_io),
    .port_out          (port_out),
    .read              (read),
    .ibf               (ibf),
    .obf_n             (obf_n),
    .intr              (intr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic [1:0] mode;
    logic       pio, inte, stb, ack, wr, rd, upd;
    logic [7:0] din, pin;
    logic       e_ibf, e_obf_n, e_intr;
    logic [7:0] e_read;
    logic       e_pio;
    logic [7:0] e_pout;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tv [NVEC];

  // Reference model: buffer-full / irq flags driven by edge events on the pins.
  logic       m_in_full, m_out_full, m_in_irq, m_out_irq, m_dir_in, m_prev_stb, m_prev_ack;
  logic [7:0] m_latch, m_captured;

  task automatic model_reset();
    m_in_full = 0; m_out_full = 0; m_in_irq = 0; m_out_irq = 0;
    m_dir_in = 1; m_prev_stb = 1; m_prev_ack = 1; m_latch = '0; m_captured = '0;
  endtask

  task automatic model_step();
    int mode;
    bit in_side, out_side, stb_fell, stb_rose, ack_fell, ack_rose;
    bit nf_in, nf_out, ni_in, ni_out;
    logic [7:0] n_cap, n_latch;
    mode     = mode_select_reg[1] ? 2 : (mode_select_reg[0] ? 1 : 0);
    in_side  = (mode == 2) || (mode == 1 && port_io_reg);
    out_side = (mode == 2) || (mode == 1 && !port_io_reg);
    stb_fell = m_prev_stb && !stb_n;
    stb_rose = !m_prev_stb && stb_n;
    ack_fell = m_prev_ack && !ack_n;
    ack_rose = !m_prev_ack && ack_n;
    n_latch  = write_port ? internal_data_bus : m_latch;
    n_cap    = (mode == 0 || (in_side && stb_fell)) ? port_in : m_captured;
    nf_in    = in_side && (stb_fell || (m_in_full && !read_port));
    ni_in    = in_side && ((stb_rose && m_in_full && inte_reg) || (m_in_irq && !read_port));
    nf_out   = out_side && (write_port || (m_out_full && !ack_fell));
    ni_out   = out_side && !write_port && ((ack_rose && !m_out_full && inte_reg) || m_out_irq);
    if (update_mode) begin
      n_latch = '0; n_cap = '0; nf_in = 0; nf_out = 0; ni_in = 0; ni_out = 0;
    end
    m_in_full = nf_in; m_out_full = nf_out; m_in_irq = ni_in; m_out_irq = ni_out;
    m_latch = n_latch; m_captured = n_cap;
    m_dir_in   = (mode == 2) ? ack_n : port_io_reg;
    m_prev_stb = stb_n;
    m_prev_ack = ack_n;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ibf"},      ibf,      m_in_full);
    check({tag, ".obf_n"},    obf_n,    !m_out_full);
    check({tag, ".intr"},     intr,     m_in_irq | m_out_irq);
    check({tag, ".port_io"},  port_io,  m_dir_in);
    check({tag, ".port_out"}, port_out, m_latch);
    check({tag, ".read"},     read,     m_dir_in ? m_captured : m_latch);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".port_io"},  port_io,  1'b1);
    check({tag, ".port_out"}, port_out, 8'h00);
    check({tag, ".read"},     read,     8'h00);
    check({tag, ".ibf"},      ibf,      1'b0);
    check({tag, ".obf_n"},    obf_n,    1'b1);
    check({tag, ".intr"},     intr,     1'b0);
  endtask

  initial begin
    //        mode  pio inte stb ack wr rd upd din    pin     ibf obf intr read  pio pout
    tv[0]  = '{2'b00, 1, 0, 1, 1, 0, 0, 0, 8'h00, 8'hA5, 0, 1, 0, 8'hA5, 1, 8'h00};
    tv[1]  = '{2'b00, 1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h5B, 0, 1, 0, 8'h5B, 1, 8'h00};
    tv[2]  = '{2'b01, 1, 1, 1, 1, 0, 0, 1, 8'h00, 8'h3C, 0, 1, 0, 8'h00, 1, 8'h00};
    tv[3]  = '{2'b01, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h3C, 1, 1, 0, 8'h3C, 1, 8'h00};
    tv[4]  = '{2'b01, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h3C, 1, 8'h00};
    tv[5]  = '{2'b01, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h3C, 1, 8'h00};
    tv[6]  = '{2'b01, 1, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h3C, 1, 8'h00};
    tv[7]  = '{2'b01, 1, 1, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h3C, 1, 8'h00};
    tv[8]  = '{2'b01, 1, 1, 0, 1, 0, 1, 0, 8'h00, 8'h77, 1, 1, 0, 8'h77, 1, 8'h00};
    tv[9]  = '{2'b01, 1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h77, 1, 8'h00};
    tv[10] = '{2'b01, 1, 0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h77, 1, 8'h00};
    tv[11] = '{2'b01, 0, 1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00};
    tv[12] = '{2'b01, 0, 1, 1, 1, 1, 0, 0, 8'h5A, 8'h00, 0, 0, 0, 8'h5A, 0, 8'h5A};
    tv[13] = '{2'b01, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h5A, 0, 8'h5A};
    tv[14] = '{2'b01, 0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h5A, 0, 8'h5A};
    tv[15] = '{2'b01, 0, 1, 1, 1, 1, 0, 0, 8'hC3, 8'h00, 0, 0, 0, 8'hC3, 0, 8'hC3};
    tv[16] = '{2'b01, 0, 1, 1, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 0, 8'h11, 0, 8'h11};
    tv[17] = '{2'b01, 0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h11, 0, 8'h11};
    tv[18] = '{2'b10, 0, 1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 8'h00};
    tv[19] = '{2'b10, 0, 1, 1, 1, 1, 0, 0, 8'hE7, 8'h00, 0, 0, 0, 8'h00, 1, 8'hE7};
    tv[20] = '{2'b10, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h81, 1, 1, 0, 8'hE7, 0, 8'hE7};
    tv[21] = '{2'b10, 0, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h81, 1, 8'hE7};
    tv[22] = '{2'b10, 0, 1, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 1, 8'h81, 1, 8'hE7};
    tv[23] = '{2'b10, 0, 1, 1, 1, 1, 0, 0, 8'h42, 8'h00, 0, 0, 0, 8'h81, 1, 8'h42};
    tv[24] = '{2'b01, 1, 1, 0, 1, 0, 0, 0, 8'h00, 8'h99, 1, 1, 0, 8'h99, 1, 8'h42};
    tv[25] = '{2'b01, 1, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h99, 1, 8'h42};
    tv[26] = '{2'b01, 1, 1, 1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 8'h00};

    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      mode_select_reg = tv[i].mode; port_io_reg = tv[i].pio; inte_reg = tv[i].inte;
      stb_n = tv[i].stb; ack_n = tv[i].ack; write_port = tv[i].wr; read_port = tv[i].rd;
      update_mode = tv[i].upd; internal_data_bus = tv[i].din; port_in = tv[i].pin;
      tick();
      check($sformatf("vec%0d.ibf", i),      ibf,      tv[i].e_ibf);
      check($sformatf("vec%0d.obf_n", i),    obf_n,    tv[i].e_obf_n);
      check($sformatf("vec%0d.intr", i),     intr,     tv[i].e_intr);
      check($sformatf("vec%0d.read", i),     read,     tv[i].e_read);
      check($sformatf("vec%0d.port_io", i),  port_io,  tv[i].e_pio);
      check($sformatf("vec%0d.port_out", i), port_out, tv[i].e_pout);
    end
    write_port = 0; read_port = 0; update_mode = 0;

    // Asynchronous reset in the middle of an input strobe.
    mode_select_reg = 2'b01; port_io_reg = 1; inte_reg = 1; stb_n = 1; ack_n = 1;
    tick();
    stb_n = 0; port_in = 8'h6D; write_port = 1; internal_data_bus = 8'h24;
    tick();
    write_port = 0;
    check("midstb.ibf", ibf, 1'b1);
    check("midstb.port_out", port_out, 8'h24);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    stb_n = 1;
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    check("post_reset.ibf_idle", ibf, 1'b0);
    stb_n = 0; port_in = 8'h12;
    tick();
    check("post_reset.ibf", ibf, 1'b1);
    check("post_reset.read", read, 8'h12);

    // Randomized traffic against the reference model.
    reset = 1'b1; stb_n = 1; ack_n = 1; read_port = 0; write_port = 0; update_mode = 0;
    #1 model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode_select_reg = 2'($urandom_range(0, 3));
        port_io_reg     = 1'($urandom_range(0, 1));
      end
      inte_reg          = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) stb_n = ~stb_n;
      if ($urandom_range(0, 2) == 0) ack_n = ~ack_n;
      write_port        = ($urandom_range(0, 4) == 0);
      read_port         = ($urandom_range(0, 4) == 0);
      update_mode       = ($urandom_range(0, 29) == 0);
      internal_data_bus = 8'($urandom);
      port_in           = 8'($urandom);
      model_step();
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
